// File: rtl/rgb2y_pipe.sv
// Three-stage RGB-to-luma converter: Y = (CR*R + CG*G + CB*B + rnd) >> FRAC, saturated to DW bits.
// A single advance enable stalls the whole pipeline; coefficients load only while it is empty.
module rgb2y_pipe #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 17,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned UW      = 2,
  parameter int unsigned ROUND   = 1,
  parameter int unsigned CR_INIT = 19595,
  parameter int unsigned CG_INIT = 38470,
  parameter int unsigned CB_INIT = 7471
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iValid,
  output logic          oReady,
  input  logic [DW-1:0] iR,
  input  logic [DW-1:0] iG,
  input  logic [DW-1:0] iB,
  input  logic [UW-1:0] iUser,
  output logic          oValid,
  input  logic          iReady,
  output logic [DW-1:0] oY,
  output logic [UW-1:0] oUser,
  input  logic          iCoefWe,
  input  logic [1:0]    iCoefSel,
  input  logic [CW-1:0] iCoefData,
  output logic          oCoefBusy
);

  localparam int unsigned PW = DW + CW;
  localparam int unsigned SW = DW + CW + 2;
  localparam logic [SW-1:0] RND = (ROUND != 0 && FRAC > 0) ? (SW'(1) << (FRAC - 1)) : '0;
  localparam logic [DW-1:0] SAT = {DW{1'b1}};

  logic          en;
  logic          coef_we;
  logic [CW-1:0] cr, cg, cb;

  logic          s1_valid;
  logic [DW-1:0] s1_r, s1_g, s1_b;
  logic [UW-1:0] s1_user;

  logic          s2_valid;
  logic [PW-1:0] p_r, p_g, p_b;
  logic [UW-1:0] s2_user;

  logic [SW-1:0] sum;
  logic [SW-1:0] shifted;
  logic [DW-1:0] y_sat;

  assign en        = ~oValid | iReady;
  assign oReady    = en | ~iReset_n;
  assign oCoefBusy = iReset_n & (s1_valid | s2_valid | oValid | iValid);
  assign coef_we   = iCoefWe & ~oCoefBusy;

  always_comb begin
    sum     = SW'(p_r) + SW'(p_g) + SW'(p_b) + RND;
    shifted = sum >> FRAC;
    y_sat   = (shifted > SW'(SAT)) ? SAT : shifted[DW-1:0];
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_user  <= '0;
      s2_valid <= 1'b0;
      p_r      <= '0;
      p_g      <= '0;
      p_b      <= '0;
      s2_user  <= '0;
      oValid   <= 1'b0;
      oY       <= '0;
      oUser    <= '0;
      cr       <= CW'(CR_INIT);
      cg       <= CW'(CG_INIT);
      cb       <= CW'(CB_INIT);
    end else begin
      if (en) begin
        s1_valid <= iValid;
        s1_r     <= iR;
        s1_g     <= iG;
        s1_b     <= iB;
        s1_user  <= iUser;
        s2_valid <= s1_valid;
        p_r      <= {{CW{1'b0}}, s1_r} * {{DW{1'b0}}, cr};
        p_g      <= {{CW{1'b0}}, s1_g} * {{DW{1'b0}}, cg};
        p_b      <= {{CW{1'b0}}, s1_b} * {{DW{1'b0}}, cb};
        s2_user  <= s1_user;
        oValid   <= s2_valid;
        // Output data only moves with a real pixel so it holds through bubbles.
        if (s2_valid) begin
          oY    <= y_sat;
          oUser <= s2_user;
        end
      end
      if (coef_we) begin
        case (iCoefSel)
          2'd0:    cr <= iCoefData;
          2'd1:    cg <= iCoefData;
          2'd2:    cb <= iCoefData;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb2y_pipe.sv
// Scoreboard bench for rgb2y_pipe: a rounding and a truncating instance share all stimulus;
// expected luma values are hand-computed and queued at each accepted input.
module tb_rgb2y_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, i_ready;
  logic [7:0] i_r, i_g, i_b;
  logic [1:0] i_user;
  logic       i_coef_we;
  logic [1:0] i_coef_sel;
  logic [16:0] i_coef_data;

  logic       o_ready, o_valid, o_busy;
  logic [7:0] o_y;
  logic [1:0] o_user;
  logic       t_ready, t_valid, t_busy;
  logic [7:0] t_y;
  logic [1:0] t_user;

  typedef struct {
    logic [7:0] y;
    logic [1:0] u;
    int         t;
    bit         lat;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  bit lat_chk  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb2y_pipe #(.ROUND(1)) dut (
    .iClk(clk), .iReset_n(rst_n), .iValid(i_valid), .oReady(o_ready),
    .iR(i_r), .iG(i_g), .iB(i_b), .iUser(i_user),
    .oValid(o_valid), .iReady(i_ready), .oY(o_y), .oUser(o_user),
    .iCoefWe(i_coef_we), .iCoefSel(i_coef_sel), .iCoefData(i_coef_data), .oCoefBusy(o_busy)
  );

  rgb2y_pipe #(.ROUND(0)) dut_t (
    .iClk(clk), .iReset_n(rst_n), .iValid(i_valid), .oReady(t_ready),
    .iR(i_r), .iG(i_g), .iB(i_b), .iUser(i_user),
    .oValid(t_valid), .iReady(i_ready), .oY(t_y), .oUser(t_user),
    .iCoefWe(i_coef_we), .iCoefSel(i_coef_sel), .iCoefData(i_coef_data), .oCoefBusy(t_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: pops on every output transfer, and checks outputs hold while stalled.
  initial begin
    logic       stall1 = 0, stall0 = 0;
    logic [7:0] py1 = 0, py0 = 0;
    logic [1:0] pu1 = 0, pu0 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (stall1 && o_valid) chk("stall_hold_y", {22'd0, o_y, o_user}, {22'd0, py1, pu1});
        if (stall0 && t_valid) chk("stall_hold_y_t", {22'd0, t_y, t_user}, {22'd0, py0, pu0});
        if (o_valid && i_ready) begin
          if (q1.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            e = q1.pop_front();
            chk("y_round", {22'd0, o_y, o_user}, {22'd0, e.y, e.u});
            if (e.lat) chk("latency", cyc - e.t, 3);
          end
        end
        if (t_valid && i_ready) begin
          if (q0.size() == 0) chk("unexpected_out_t", 1, 0);
          else begin
            e = q0.pop_front();
            chk("y_trunc", {22'd0, t_y, t_user}, {22'd0, e.y, e.u});
          end
        end
        stall1 = o_valid && !i_ready;
        stall0 = t_valid && !i_ready;
        py1 = o_y; pu1 = o_user;
        py0 = t_y; pu0 = t_user;
      end else begin
        stall1 = 0;
        stall0 = 0;
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [1:0] u, input logic [7:0] e1, input logic [7:0] e0,
                      input logic we, input logic [1:0] sel, input logic [16:0] data);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    i_valid = 1; i_r = r; i_g = g; i_b = b; i_user = u;
    i_coef_we = we; i_coef_sel = sel; i_coef_data = data;
    #1;
    while (!o_ready && guard < 50) begin
      @(negedge clk);
      i_coef_we = 0;
      #1;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 0, 1);
    else begin
      e.u = u; e.t = cyc; e.lat = lat_chk;
      e.y = e1; q1.push_back(e);
      e.y = e0; q0.push_back(e);
    end
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [1:0] u, input logic [7:0] e1, input logic [7:0] e0);
    send(r, g, b, u, e1, e0, 1'b0, 2'd0, 17'd0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_valid = 0; i_coef_we = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [16:0] data);
    @(negedge clk);
    i_valid = 0; i_coef_we = 1; i_coef_sel = sel; i_coef_data = data;
    @(negedge clk);
    i_coef_we = 0;
  endtask

  // Primaries and white with expected rounded / truncated luma.
  logic [7:0] tr[4] = '{8'd255, 8'd0,   8'd0,   8'd255};
  logic [7:0] tg[4] = '{8'd0,   8'd255, 8'd0,   8'd255};
  logic [7:0] tb[4] = '{8'd0,   8'd0,   8'd255, 8'd255};
  logic [7:0] t1[4] = '{8'd76,  8'd150, 8'd29,  8'd255};
  logic [7:0] t0[4] = '{8'd76,  8'd149, 8'd29,  8'd255};

  initial begin
    int guard;
    rst_n = 0; i_valid = 0; i_ready = 1; i_r = 0; i_g = 0; i_b = 0; i_user = 0;
    i_coef_we = 0; i_coef_sel = 0; i_coef_data = 0;
    repeat (2) @(negedge clk);
    #1 chk("ready_in_reset", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_y", o_y, 0);
    chk("rst_user", o_user, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid_t", t_valid, 0);

    // Back-to-back stream, latency checked.
    lat_chk = 1;
    for (int i = 0; i < 4; i++) px(tr[i], tg[i], tb[i], 2'(i), t1[i], t0[i]);
    px(8'd0, 8'd0, 8'd0, 2'd1, 8'd0, 8'd0);
    lat_chk = 0;
    idle(6);

    // Continuous stream with a 4-cycle downstream stall.
    fork
      for (int i = 0; i < 12; i++) px(tr[i % 4], tg[i % 4], tb[i % 4], 2'((i * 3) % 4),
                                      t1[i % 4], t0[i % 4]);
      begin
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          i_ready = 0;
          #1 chk("bp_ready_low", o_ready, 0);
        end
        @(negedge clk);
        i_ready = 1;
      end
    join
    idle(8);

    // Writes while busy (with iValid, then with only stage valids) are dropped.
    send(8'd255, 8'd0, 8'd0, 2'd2, 8'd76, 8'd76, 1'b1, 2'd0, 17'd0);
    @(negedge clk);
    i_valid = 0; i_coef_we = 1; i_coef_sel = 2'd1; i_coef_data = 17'd0;
    #1 chk("busy_flag", o_busy, 1);
    idle(6);
    wr(2'd3, 17'd0);
    px(8'd255, 8'd0, 8'd0, 2'd0, 8'd76, 8'd76);
    px(8'd0, 8'd255, 8'd0, 2'd1, 8'd150, 8'd149);
    px(8'd0, 8'd0, 8'd255, 2'd2, 8'd29, 8'd29);
    idle(6);

    // Runtime coefficient loads.
    wr(2'd0, 17'd65535);
    px(8'd255, 8'd255, 8'd255, 2'd3, 8'd255, 8'd255);
    idle(6);
    wr(2'd0, 17'd0);
    wr(2'd1, 17'd0);
    wr(2'd2, 17'd65536);
    px(8'd10, 8'd20, 8'd30, 2'd1, 8'd30, 8'd30);
    idle(6);

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) px(8'd10, 8'd20, 8'd30, 2'(i), 8'd30, 8'd30);
    @(negedge clk);
    rst_n = 0; i_valid = 0; i_ready = 0;
    #1 chk("ready_in_reset_full", o_ready, 1);
    #1;
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1; i_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_reset_no_valid", o_valid, 0);
      chk("post_reset_no_valid_t", t_valid, 0);
      @(negedge clk);
    end
    px(8'd0, 8'd255, 8'd0, 2'd2, 8'd150, 8'd149);
    idle(2);

    guard = 0;
    while ((q1.size() != 0 || q0.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_q", q1.size(), 0);
    chk("drain_q_t", q0.size(), 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
